// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the fifo_fwft_sync slice: default geometry, the
//   occupancy-counter width formula and the per-cycle transfer encoding.
// ----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 16;

  // Per-cycle transfer kind, encoded as {pop, push} so it can be built by a
  // plain cast of the two handshake strobes.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Occupancy runs 0..DEPTH inclusive, so it needs one bit more than a pointer.
  function automatic int count_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// ----------------------------------------------------------------------------
// fifo_mem
//   DEPTH x DATA_W register array with one synchronous write port and one
//   asynchronous (combinational) read port. Contents are not reset.
//
// Ports
//   clk    in   clock, rising edge
//   we     in   write enable
//   waddr  in   write address  [ADDR_W-1:0]
//   wdata  in   write data     [DATA_W-1:0]
//   raddr  in   read address   [ADDR_W-1:0]
//   rdata  out  read data      [DATA_W-1:0], follows raddr combinationally
// ----------------------------------------------------------------------------
module fifo_mem
  import fifo_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  parameter  int DEPTH  = DEFAULT_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array deliberately has no reset; every readable entry is written
  // before the pointers let it be read, and a reset here would stop the array
  // mapping onto plain storage cells.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_fwft_sync.sv
// ----------------------------------------------------------------------------
// fifo_fwft_sync
//   Synchronous first-word-fall-through FIFO with valid/ready handshake on
//   both sides, registered occupancy count, full/empty flags and a
//   synchronous flush. The head entry is presented on rd_data with no read
//   latency; a word pushed on edge N is visible in cycle N+1.
//
// Configuration
//   FIFO_ERR_FLAGS_EN  when defined, adds sticky overflow/underflow outputs.
//
// Parameters
//   DATA_W  data width in bits (>= 1)
//   DEPTH   number of entries, power of two, >= 2
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   flush      in   synchronous clear of pointers, count and error flags
//   wr_valid   in   producer has data
//   wr_ready   out  FIFO can accept data (= !full)
//   wr_data    in   write data
//   rd_valid   out  head entry valid (= !empty)
//   rd_ready   in   consumer takes head
//   rd_data    out  head entry, 0 while empty
//   count      out  occupancy 0..DEPTH
//   full       out  count == DEPTH
//   empty      out  count == 0
//   overflow   out  sticky: write attempted while full   (FIFO_ERR_FLAGS_EN)
//   underflow  out  sticky: read attempted while empty   (FIFO_ERR_FLAGS_EN)
// ----------------------------------------------------------------------------
module fifo_fwft_sync
  import fifo_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  parameter  int DEPTH  = DEFAULT_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W  = count_w(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
`ifdef FIFO_ERR_FLAGS_EN
  output logic              overflow,
  output logic              underflow,
`endif
  output logic              empty
);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_next;
  logic [DATA_W-1:0] mem_rdata;
  logic              push;
  logic              pop;
  fifo_op_e          op;

  // Flags come only from the registered count, so wr_ready/rd_valid never
  // depend combinationally on wr_valid or rd_ready.
  assign full     = (count_q == FULL_COUNT);
  assign empty    = (count_q == '0);
  assign wr_ready = !full;
  assign rd_valid = !empty;
  assign count    = count_q;

  assign push = wr_valid & wr_ready;
  assign pop  = rd_valid & rd_ready;
  assign op   = fifo_op_e'({pop, push});

  // NOTE: count_next gets its default before the case so that every path
  // assigns it and no latch is inferred.
  always_comb begin
    count_next = count_q;
    case (op)
      OP_PUSH: count_next = count_q + 1'b1;
      OP_POP:  count_next = count_q - 1'b1;
      default: count_next = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_next;
    end
  end

  // Flush drops the write in the same cycle; mem contents are otherwise kept.
  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push & !flush),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  // Stale array contents must never leak out while the FIFO is empty.
  assign rd_data = empty ? '0 : mem_rdata;

`ifdef FIFO_ERR_FLAGS_EN
  // Observation only: these flags never gate the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_valid && !wr_ready) overflow  <= 1'b1;
      if (rd_ready && !rd_valid) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_fwft_sync.sv
// ----------------------------------------------------------------------------
// tb_fifo_fwft_sync
//   Self-checking bench for fifo_fwft_sync (DATA_W=8, DEPTH=16). A queue-based
//   reference model tracks contents; each scenario task compares the DUT's
//   status vector and popped data against it. Error-flag checks are compiled
//   in when FIFO_ERR_FLAGS_EN is defined.
// ----------------------------------------------------------------------------
module tb_fifo_fwft_sync;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [4:0]        count;
  logic              full;
  logic              empty;
  logic [1:0]        dut_flags;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow;
  logic underflow;
  assign dut_flags = {overflow, underflow};
`else
  assign dut_flags = 2'b00;
`endif

  fifo_fwft_sync #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .count     (count),
    .full      (full),
`ifdef FIFO_ERR_FLAGS_EN
    .overflow  (overflow),
    .underflow (underflow),
`endif
    .empty     (empty)
  );

  always #5 clk = ~clk;

  // {count, empty, full, rd_valid, wr_ready, rd_data, overflow, underflow}
  logic [18:0] dut_status;
  assign dut_status = {count, empty, full, rd_valid, wr_ready, rd_data, dut_flags};

  // Reference model.
  logic [DATA_W-1:0] model_q[$];
  logic              model_ovf = 1'b0;
  logic              model_unf = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  // Values observed / expected for the most recent drive() call.
  logic              last_pop;
  logic [DATA_W-1:0] last_rd;
  logic [DATA_W-1:0] last_exp_rd;

  function automatic logic [18:0] exp_status();
    int n;
    logic [DATA_W-1:0] head;
    n    = model_q.size();
    head = (n != 0) ? model_q[0] : '0;
    return {5'(n), n == 0, n == DEPTH, n != 0, n != DEPTH, head, model_ovf, model_unf};
  endfunction

  // One clock of stimulus; updates the model from the handshake rules.
  task automatic drive(input logic wv, input logic [DATA_W-1:0] wd,
                       input logic rr, input logic fl);
    logic do_push, do_pop;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    do_push  = wv && (model_q.size() < DEPTH);
    do_pop   = rr && (model_q.size() > 0);
    #1;
    last_rd     = rd_data;
    last_pop    = do_pop && !fl;
    last_exp_rd = (model_q.size() > 0) ? model_q[0] : '0;
    @(posedge clk);
    if (fl) begin
      model_q.delete();
`ifdef FIFO_ERR_FLAGS_EN
      model_ovf = 1'b0;
      model_unf = 1'b0;
`endif
    end else begin
`ifdef FIFO_ERR_FLAGS_EN
      if (wv && !do_push) model_ovf = 1'b1;
      if (rr && model_q.size() == 0) model_unf = 1'b1;
`endif
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(wd);
    end
    #1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if (dut_status !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 2'b00}) begin
      tests_failed++;
      $display("FAIL reset_idle: got %h expected %h", dut_status,
               {5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 2'b00});
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tests_run++;
    if (dut_status !== exp_status()) begin
      tests_failed++;
      $display("FAIL reset_idle_cycle: got %h expected %h", dut_status, exp_status());
    end
  endtask

  task automatic test_latency();
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    tests_run++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || count !== 5'd1) begin
      tests_failed++;
      $display("FAIL latency_visible: got valid=%b data=%h count=%0d expected valid=1 data=a5 count=1",
               rd_valid, rd_data, count);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tests_run++;
    if (empty !== 1'b1 || last_rd !== 8'hA5 || dut_status !== exp_status()) begin
      tests_failed++;
      $display("FAIL latency_pop: got empty=%b popped=%h status=%h expected empty=1 popped=a5 status=%h",
               empty, last_rd, dut_status, exp_status());
    end
  endtask

  task automatic test_fill_wrap();
    int expect_next = 0;
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
    tests_run++;
    if (full !== 1'b1 || wr_ready !== 1'b0 || count !== 5'd16) begin
      tests_failed++;
      $display("FAIL fill_full: got full=%b wr_ready=%b count=%0d expected 1 0 16",
               full, wr_ready, count);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      tests_run++;
      if (last_rd !== 8'(expect_next)) begin
        tests_failed++;
        $display("FAIL wrap_order: got %h expected %h", last_rd, 8'(expect_next));
      end
      expect_next++;
    end
    for (int i = 16; i < 24; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
    tests_run++;
    if (dut_status !== exp_status() || count !== 5'd16) begin
      tests_failed++;
      $display("FAIL wrap_refill: got %h expected %h", dut_status, exp_status());
    end
    while (expect_next < 24) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      tests_run++;
      if (last_rd !== 8'(expect_next)) begin
        tests_failed++;
        $display("FAIL wrap_order: got %h expected %h", last_rd, 8'(expect_next));
      end
      expect_next++;
    end
    tests_run++;
    if (empty !== 1'b1 || rd_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL wrap_drained: got empty=%b data=%h expected empty=1 data=00", empty, rd_data);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 5; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'($urandom), 1'b1, 1'b0);
      tests_run++;
      if (count !== 5'd5 || last_rd !== last_exp_rd || dut_status !== exp_status()) begin
        tests_failed++;
        $display("FAIL simul_mid: got count=%0d popped=%h status=%h expected count=5 popped=%h status=%h",
                 count, last_rd, dut_status, last_exp_rd, exp_status());
      end
    end
    while (model_q.size() < DEPTH) drive(1'b1, 8'($urandom), 1'b0, 1'b0);
    drive(1'b1, 8'hEE, 1'b1, 1'b0);
    tests_run++;
    if (count !== 5'd15 || dut_status !== exp_status()) begin
      tests_failed++;
      $display("FAIL simul_full: got count=%0d status=%h expected count=15 status=%h",
               count, dut_status, exp_status());
    end
    while (model_q.size() > 0) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      tests_run++;
      if (last_rd !== last_exp_rd) begin
        tests_failed++;
        $display("FAIL simul_drain: got %h expected %h", last_rd, last_exp_rd);
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 7; i++) drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    drive(1'b1, 8'hEE, 1'b0, 1'b1);
    tests_run++;
    if (count !== 5'd0 || empty !== 1'b1 || rd_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL flush_clear: got count=%0d empty=%b data=%h expected 0 1 00",
               count, empty, rd_data);
    end
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    tests_run++;
    if (rd_data !== 8'h3C || count !== 5'd1) begin
      tests_failed++;
      $display("FAIL flush_next_push: got data=%h count=%0d expected 3c 1", rd_data, count);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

`ifdef FIFO_ERR_FLAGS_EN
  task automatic test_err_flags();
    while (model_q.size() < DEPTH) drive(1'b1, 8'($urandom), 1'b0, 1'b0);
    drive(1'b1, 8'h99, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tests_run++;
    if (dut_flags !== 2'b10 || dut_status !== exp_status()) begin
      tests_failed++;
      $display("FAIL err_overflow: got flags=%b expected 10", dut_flags);
    end
    while (model_q.size() > 0) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      tests_run++;
      if (last_rd !== last_exp_rd) begin
        tests_failed++;
        $display("FAIL err_data: got %h expected %h", last_rd, last_exp_rd);
      end
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tests_run++;
    if (dut_flags !== 2'b11) begin
      tests_failed++;
      $display("FAIL err_underflow: got flags=%b expected 11", dut_flags);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tests_run++;
    if (dut_flags !== 2'b00) begin
      tests_failed++;
      $display("FAIL err_flush: got flags=%b expected 00", dut_flags);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 39) == 0));
      tests_run++;
      if (dut_status !== exp_status() || (last_pop && last_rd !== last_exp_rd)) begin
        tests_failed++;
        $display("FAIL random[%0d]: got status=%h popped=%h expected status=%h popped=%h",
                 i, dut_status, last_rd, exp_status(), last_exp_rd);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    model_unf = 1'b0;
    #1;
    tests_run++;
    if (dut_status !== exp_status()) begin
      tests_failed++;
      $display("FAIL reset_mid_async: got %h expected %h", dut_status, exp_status());
    end
    #1 rst_n = 1'b1;
    drive(1'b1, 8'h5A, 1'b0, 1'b0);
    tests_run++;
    if (rd_data !== 8'h5A || count !== 5'd1 || dut_status !== exp_status()) begin
      tests_failed++;
      $display("FAIL reset_mid_first: got %h expected %h", dut_status, exp_status());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;
    #12 rst_n = 1'b1;
    #2;
    test_reset();
    test_latency();
    test_fill_wrap();
    test_simultaneous();
    test_flush();
`ifdef FIFO_ERR_FLAGS_EN
    test_err_flags();
`endif
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fifo_fwft_sync.md
Name: fifo_fwft_sync

Overview:
- Parametrised synchronous FIFO with first-word-fall-through (FWFT) read; next generation of the team's single-stage enable register.
- Adds configurable width and depth, a valid/ready handshake on both sides, occupancy count, full/empty flags and a synchronous flush.
- Single clock domain. Sits between a producer and consumer that need rate decoupling without read latency.

Parameters:
- DATA_W, 8, data bus width in bits (≥1).
- DEPTH, 16, number of entries; power of two, ≥2.
- ADDR_W, $clog2(DEPTH), derived localparam (not overridable); pointer width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of FIFO state.
- wr_valid  in  1  producer has data.
- wr_ready  out  1  FIFO can accept data (= !full).
- wr_data  in  DATA_W  write data.
- rd_valid  out  1  head entry valid (= !empty).
- rd_ready  in  1  consumer takes head.
- rd_data  out  DATA_W  head entry (FWFT).
- count  out  ADDR_W+1  occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky error; present only with FIFO_ERR_FLAGS_EN.
- underflow  out  1  sticky error; present only with FIFO_ERR_FLAGS_EN.

Behaviour:
- Reset: clk and rst_n (asynchronous, active-low) as decided.
  - rst_n low asynchronously sets wr_ptr=0, rd_ptr=0, count=0.
  - Outputs under reset: empty=1, full=0, wr_ready=1, rd_valid=0, rd_data=0, overflow=0, underflow=0.
  - Storage array is not reset.
- Handshake:
  - push = wr_valid & wr_ready.
  - pop = rd_valid & rd_ready.
  - Transfer occurs on a rising edge where push or pop is true.
- Latency:
  - Word pushed at edge N gives rd_valid=1 and rd_data=that word after edge N, i.e. visible in cycle N+1.
  - No read latency: rd_data = mem[rd_ptr] combinationally while rd_valid=1.
  - rd_data is forced to 0 while empty.
- Push: mem[wr_ptr] <= wr_data, then wr_ptr++.
- Pop: rd_ptr++.
- Pointers wrap naturally modulo DEPTH (ADDR_W bits).
- Count update:
  - push only: +1.
  - pop only: -1.
  - both or neither: unchanged.
- full, empty and count are all derived from the registered count; no combinational path from wr_valid or rd_ready.
- Full:
  - wr_ready=0, so a push is impossible.
  - A simultaneous pop while full frees one slot only from the next cycle; there is no same-cycle pass-through.
- Empty:
  - rd_valid=0, so a pop is impossible.
  - A simultaneous wr_valid while empty is accepted. It does not bypass to rd_data in the same cycle.
- Simultaneous push and pop when 0<count<DEPTH: both occur and count is unchanged.
- Flush:
  - Takes priority over push and pop in the same cycle; the write data is dropped.
  - Sets pointers=0, count=0 and clears the sticky flags.
  - mem contents are untouched.
- Reset mid-operation: all in-flight data is lost. The first edge after rst_n deasserts behaves as an empty FIFO.

Optional Feature:
- Macro FIFO_ERR_FLAGS_EN.
- When defined:
  - overflow and underflow ports exist.
  - overflow is set on any edge with wr_valid & !wr_ready.
  - underflow is set on any edge with rd_ready & !rd_valid.
  - Both are sticky until reset or flush.
  - Neither flag affects the datapath.
- When undefined: the ports and their logic are absent. The block behaves identically otherwise.

Decomposition:
- Shared package fifo_pkg holds:
  - default DATA_W and DEPTH constants;
  - a clog2 helper function, if the toolchain needs it;
  - the count-width formula ADDR_W+1.
- One sub-module, fifo_mem:
  - DEPTH x DATA_W register array;
  - one synchronous write port (we, waddr, wdata);
  - one asynchronous read port (raddr → rdata).
- Pointer, count and handshake logic live in fifo_fwft_sync.

Test Plan:
- Reset then idle: after rst_n release, empty=1, full=0, count=0, rd_data=0, wr_ready=1.
- Latency: push 0xA5 at edge N (rd_ready=0). Cycle N+1: rd_valid=1, rd_data=0xA5, count=1. Pop at edge N+1 gives empty=1.
- Fill and wrap (DEPTH=16, DATA_W=8): push 0x00..0x0F, then full=1, wr_ready=0, count=16. Pop 8, push 0x10..0x17, drain all. Output order must be 0x00..0x17.
- Simultaneous traffic: with count=5, wr_valid=rd_ready=1 for 20 cycles gives count held at 5 and in-order data. With count=16, both asserted gives pop only, count=15, and the write is not accepted.
- Flush: count=7 with flush=1 and wr_valid=1 in the same cycle gives count=0, empty=1 and the write dropped. The next push of 0x3C appears at rd_data.
- Error flags (FIFO_ERR_FLAGS_EN):
  - wr_valid=1 while full sets overflow=1, which stays set.
  - rd_ready=1 while empty sets underflow=1.
  - Flush clears both.
  - Data integrity is unaffected.
